inst_cache: RTL and testbench

Direct-mapped, read-only instruction cache between the CPU fetch port (`rom_ce`/`rom_addr`/`rom_inst`) and a slower instruction memory with a per-word request/acknowledge handshake. Hits return the instruction combinationally in the same cycle, exactly like a ROM. Misses stall the CPU while a four-word line is refilled. The block replaces the direct CPU-to-ROM connection in the SoPC top level.

---
 rtl/inst_cache.sv | 177 +++++++++++++++++
 tb/tb_inst_cache.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache.sv
// -----------------------------------------------------------------------------
// inst_cache
//
// Direct-mapped, read-only instruction cache that sits between the CPU fetch
// port and a slower instruction memory. A hit returns the instruction
// combinationally in the same cycle, like a ROM. A miss stalls the CPU while
// a four-word line is refilled one word at a time through a request /
// acknowledge handshake.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   cpu_ce     fetch enable from the CPU
//   cpu_addr   byte fetch address (bits [1:0] ignored)
//   flush      invalidate every line (fence.i)
//   cpu_inst   instruction returned to the CPU, 0 when not valid
//   cpu_stall  high when cpu_inst is not valid this cycle
//   mem_req    word read request to instruction memory
//   mem_addr   word-aligned read address, 0 whenever mem_req is low
//   mem_ack    memory returns mem_data this cycle
//   mem_data   read data from memory, valid with mem_ack
// -----------------------------------------------------------------------------
module inst_cache #(
    parameter int LINE_NUM = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce,
    input  logic [31:0] cpu_addr,
    input  logic        flush,
    output logic [31:0] cpu_inst,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data
);

    localparam int IDX_W = $clog2(LINE_NUM);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    state_t              state_q, state_d;
    logic [LINE_NUM-1:0] valid_q, valid_d;
    logic [27:0]         lineBase_q, lineBase_d;
    logic [1:0]          wordCnt_q, wordCnt_d;
    logic                flushPend_q, flushPend_d;

    logic [TAG_W-1:0]    tagMem  [LINE_NUM];
    logic [31:0]         dataMem [LINE_NUM][4];

    logic [1:0]          reqOffset;
    logic [IDX_W-1:0]    reqIndex;
    logic [TAG_W-1:0]    reqTag;
    logic [IDX_W-1:0]    fillIndex;
    logic [TAG_W-1:0]    fillTag;
    logic                lookupHit;
    logic                fillWrite;
    logic                fillLast;
    logic                addrUnused;

    // Split the fetch address into word offset, line index and tag. The byte
    // offset bits carry no information for word-aligned instruction fetches.
    assign reqOffset  = cpu_addr[3:2];
    assign reqIndex   = cpu_addr[4 +: IDX_W];
    assign reqTag     = cpu_addr[31 -: TAG_W];
    assign addrUnused = ^cpu_addr[1:0];

    // The line being refilled is identified by the latched line base address,
    // so the CPU is free to change cpu_addr while the refill is running.
    assign fillIndex = lineBase_q[IDX_W-1:0];
    assign fillTag   = lineBase_q[27 -: TAG_W];

    // A hit needs a valid line whose stored tag matches. The valid bit is
    // tested first because tag storage is never reset.
    assign lookupHit = valid_q[reqIndex] && (tagMem[reqIndex] == reqTag);

    // Acknowledges only count while refilling; a stray mem_ack in IDLE must
    // not corrupt the data array.
    assign fillWrite = (state_q == REFILL) && mem_ack;
    assign fillLast  = fillWrite && (wordCnt_q == 2'd3);

    // The memory request is decoded from registered state only, so it never
    // depends combinationally on the CPU address.
    assign mem_req  = (state_q == REFILL);
    assign mem_addr = mem_req ? {lineBase_q, wordCnt_q, 2'b00} : 32'd0;

    // State register. Reset returns to IDLE and invalidates every line, which
    // also abandons any refill in flight without marking its line valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            lineBase_q  <= '0;
            wordCnt_q   <= '0;
            flushPend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            lineBase_q  <= lineBase_d;
            wordCnt_q   <= wordCnt_d;
            flushPend_q <= flushPend_d;
        end
    end

    // Tag and data storage have no reset; they are only meaningful once the
    // matching valid bit is set. Each acknowledged word lands in the slot
    // selected by the word counter, and the tag is written with the last one.
    always_ff @(posedge clk) begin
        if (fillWrite) begin
            dataMem[fillIndex][wordCnt_q] <= mem_data;
        end
        if (fillLast) begin
            tagMem[fillIndex] <= fillTag;
        end
    end

    // Next-state and CPU-side outputs. In IDLE a hit is served directly from
    // the array; a miss stalls immediately and latches the line base. During
    // REFILL a flush cannot drop the line being written, so it is remembered
    // and applied when the refill finishes, leaving that line invalid too.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        lineBase_d  = lineBase_q;
        wordCnt_d   = wordCnt_q;
        flushPend_d = flushPend_q;
        cpu_inst    = 32'd0;
        cpu_stall   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_ce) begin
                    if (lookupHit) begin
                        cpu_inst = dataMem[reqIndex][reqOffset];
                    end else begin
                        cpu_stall  = 1'b1;
                        lineBase_d = cpu_addr[31:4];
                        wordCnt_d  = 2'd0;
                        state_d    = REFILL;
                    end
                end
                if (flush) begin
                    valid_d = '0;
                end
            end

            REFILL: begin
                cpu_stall = 1'b1;
                if (flush) begin
                    flushPend_d = 1'b1;
                end
                if (mem_ack) begin
                    wordCnt_d = wordCnt_q + 2'd1;
                    if (wordCnt_q == 2'd3) begin
                        state_d     = IDLE;
                        flushPend_d = 1'b0;
                        if (flushPend_q || flush) begin
                            valid_d = '0;
                        end else begin
                            valid_d[fillIndex] = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_cache.sv
// -----------------------------------------------------------------------------
// tb_inst_cache
//
// Self-checking bench for inst_cache. A behavioural instruction memory answers
// each request with data 0x100 + (byte address / 4) after a configurable
// number of wait cycles and logs the addresses it served. Hits are checked
// from a table of vectors; misses, waits, flushes and reset during a refill
// are exercised by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_inst_cache;

    logic        clk;
    logic        rst;
    logic        cpu_ce;
    logic [31:0] cpu_addr;
    logic        flush;
    logic [31:0] cpu_inst;
    logic        cpu_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;

    int          checks = 0;
    int          errors = 0;
    int          waitCycles = 0;
    int          waitCnt = 0;
    bit          spuriousAck = 1'b0;
    logic [31:0] holdAddr;
    logic [31:0] addrLog [$];

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic        fl;
        logic [31:0] expInst;
        logic        expStall;
        logic        expReq;
    } vec_t;

    vec_t vecs [7];

    inst_cache #(.LINE_NUM(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_ce    (cpu_ce),
        .cpu_addr  (cpu_addr),
        .flush     (flush),
        .cpu_inst  (cpu_inst),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Contents of the backing instruction memory.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'h100 + {2'b00, a[31:2]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ce, input logic [31:0] addr, input logic fl);
        cpu_ce   = ce;
        cpu_addr = addr;
        flush    = fl;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Present a fetch and count how many cycles it stalls, then check the
    // instruction delivered in the first non-stalled cycle.
    task automatic measureMiss(input string name, input logic [31:0] addr,
                               input int expCycles, input logic [31:0] expInst);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        applyStimulus(1'b1, addr, 1'b0);
        for (int k = 0; k < 400; k++) begin
            #1;
            if (!cpu_stall) begin
                done = 1'b1;
                break;
            end
            n++;
            nextCycle();
        end
        checkOutput({name, "_done"}, 32'(done), 32'd1);
        checkOutput({name, "_stallCycles"}, 32'(n), 32'(expCycles));
        checkOutput({name, "_inst"}, cpu_inst, expInst);
        nextCycle();
    endtask

    task automatic checkLog(input string name, input logic [31:0] base);
        logic [31:0] got;
        checkOutput({name, "_reqCount"}, 32'(addrLog.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            got = (i < addrLog.size()) ? addrLog[i] : 32'hFFFF_FFFF;
            checkOutput({name, "_memAddr"}, got, base + 32'(4 * i));
        end
    endtask

    // Instruction memory model: acknowledges each request after waitCycles
    // idle cycles and checks that the request address holds during waits.
    always @(negedge clk) begin
        if (mem_req) begin
            if (waitCnt == 0) begin
                holdAddr = mem_addr;
            end else begin
                checkOutput("memAddrStable", mem_addr, holdAddr);
            end
            if (waitCnt < waitCycles) begin
                mem_ack = 1'b0;
                waitCnt++;
            end else begin
                mem_ack  = 1'b1;
                mem_data = memWord(mem_addr);
                addrLog.push_back(mem_addr);
                waitCnt  = 0;
            end
        end else begin
            mem_ack  = spuriousAck;
            mem_data = 32'hDEAD_BEEF;
            waitCnt  = 0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Hits on line 0 after its first refill, with junk acks in IDLE.
        vecs[0] = '{1'b1, 32'h4, 1'b0, 32'h101, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h8, 1'b0, 32'h102, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'hC, 1'b0, 32'h103, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 32'hC, 1'b0, 32'h0,   1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'h3, 1'b0, 32'h100, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'hE, 1'b0, 32'h103, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0};

        mem_ack  = 1'b0;
        mem_data = 32'd0;
        rst      = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("reset_stall", 32'(cpu_stall), 32'd0);
        checkOutput("reset_inst", cpu_inst, 32'd0);
        checkOutput("reset_memReq", 32'(mem_req), 32'd0);
        checkOutput("reset_memAddr", mem_addr, 32'd0);
        nextCycle();

        // Cold miss on 0x0: one miss cycle plus four refill cycles.
        addrLog.delete();
        measureMiss("miss0", 32'h0, 5, 32'h100);
        checkLog("fill0", 32'h0);

        spuriousAck = 1'b1;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].ce, vecs[i].addr, vecs[i].fl);
            #1;
            checkOutput($sformatf("vec%0d_inst", i), cpu_inst, vecs[i].expInst);
            checkOutput($sformatf("vec%0d_stall", i), 32'(cpu_stall), 32'(vecs[i].expStall));
            checkOutput($sformatf("vec%0d_memReq", i), 32'(mem_req), 32'(vecs[i].expReq));
            nextCycle();
        end
        spuriousAck = 1'b0;

        // The flush in the last vector invalidated line 0.
        measureMiss("missAfterFlush", 32'h0, 5, 32'h100);

        // Conflict on index 0: 0x100 evicts 0x0, then 0x0 comes back.
        measureMiss("conflict100", 32'h100, 5, 32'h140);
        measureMiss("conflict0", 32'h0, 5, 32'h100);

        // Three wait cycles before every ack.
        waitCycles = 3;
        addrLog.delete();
        measureMiss("wait20", 32'h20, 17, 32'h108);
        checkLog("wait20", 32'h20);
        waitCycles = 0;

        // Flush during the second refill word of line 0x40.
        applyStimulus(1'b1, 32'h40, 1'b0);
        #1;
        checkOutput("miss40_stall", 32'(cpu_stall), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 32'h40, 1'b0);
        #1;
        checkOutput("fill40_word0Addr", mem_addr, 32'h40);
        nextCycle();
        applyStimulus(1'b0, 32'h40, 1'b1);
        #1;
        checkOutput("fill40_word1Addr", mem_addr, 32'h44);
        checkOutput("fill40_stall", 32'(cpu_stall), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 32'h40, 1'b0);
        begin
            bit idle;
            idle = 1'b0;
            for (int k = 0; k < 50; k++) begin
                #1;
                if (!mem_req) begin
                    idle = 1'b1;
                    break;
                end
                nextCycle();
            end
            checkOutput("fill40_complete", 32'(idle), 32'd1);
        end
        nextCycle();
        measureMiss("refetch40", 32'h40, 5, 32'h110);
        measureMiss("refetch0", 32'h0, 5, 32'h100);

        // Reset asserted in the third refill cycle of line 0x80.
        applyStimulus(1'b1, 32'h80, 1'b0);
        nextCycle();
        nextCycle();
        nextCycle();
        rst = 1'b1;
        applyStimulus(1'b0, 32'h80, 1'b0);
        nextCycle();
        rst = 1'b0;
        #1;
        checkOutput("rstRefill_memReq", 32'(mem_req), 32'd0);
        checkOutput("rstRefill_memAddr", mem_addr, 32'd0);
        nextCycle();
        addrLog.delete();
        measureMiss("afterRst80", 32'h80, 5, 32'h120);
        checkLog("afterRst80", 32'h80);
        measureMiss("afterRst40", 32'h40, 5, 32'h110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
